// File: rtl/rr_channel_arbiter.sv
// Round-robin N-to-1 pull arbiter: fetches one word from a source over req/ack, buffers it,
// and forwards it downstream over req/ack tagged with its source index.
module rr_channel_arbiter #(
  parameter int unsigned data_width = 32,
  parameter int unsigned num_inputs = 4,
  parameter int unsigned wait_limit = 16,
  localparam int unsigned SW = (num_inputs > 1) ? $clog2(num_inputs) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [num_inputs-1:0]            en_mask,
  output logic [num_inputs-1:0]            req_in,
  input  logic [num_inputs-1:0]            ack_in,
  input  logic [data_width*num_inputs-1:0] din,
  input  logic                             req_out,
  output logic                             ack_out,
  output logic [data_width-1:0]            dout,
  output logic [SW-1:0]                    sel_out,
  output logic [31:0]                      grant_count,
  output logic [15:0]                      timeout_count
);

  typedef enum logic [1:0] {StIdle, StWait, StDrain, StFull} state_e;

  localparam logic [num_inputs-1:0] OneHot0 = 1;

  state_e                  state_q, state_d;
  logic [SW-1:0]           ptr_q, ptr_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic [SW-1:0]           sel_out_q, sel_out_d;
  logic [31:0]             wcnt_q, wcnt_d;
  logic [num_inputs-1:0]   req_in_q, req_in_d;
  logic                    ack_out_q, ack_out_d;
  logic [data_width-1:0]   dout_q, dout_d;
  logic [31:0]             grant_q, grant_d;
  logic [15:0]             tmo_q, tmo_d;

  logic                    ack_sel;
  logic [data_width-1:0]   din_sel;
  logic [SW-1:0]           ptr_nxt;
  logic [SW-1:0]           pick, pick_any, pick_hi;
  logic                    hi_found;
  logic                    timeout_hit;

  assign ack_sel     = ack_in[sel_q];
  assign din_sel     = din[32'(sel_q) * data_width +: data_width];
  assign ptr_nxt     = (sel_q == SW'(num_inputs - 1)) ? '0 : sel_q + SW'(1);
  assign timeout_hit = (wait_limit != 0) && (wcnt_q == wait_limit - 1);

  // Cyclic search: lowest enabled index >= ptr, else wrap to the lowest enabled index overall.
  always_comb begin
    pick_any = '0;
    pick_hi  = '0;
    hi_found = 1'b0;
    for (int j = int'(num_inputs) - 1; j >= 0; j--) begin
      if (en_mask[j]) begin
        pick_any = SW'(j);
        if (SW'(j) >= ptr_q) begin
          pick_hi  = SW'(j);
          hi_found = 1'b1;
        end
      end
    end
    pick = hi_found ? pick_hi : pick_any;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    sel_out_d = sel_out_q;
    wcnt_d    = wcnt_q;
    req_in_d  = req_in_q;
    ack_out_d = 1'b0;
    dout_d    = dout_q;
    grant_d   = grant_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (|en_mask) begin
          sel_d    = pick;
          req_in_d = OneHot0 << pick;
          wcnt_d   = '0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (ack_sel) begin
          dout_d    = din_sel;
          sel_out_d = sel_q;
          req_in_d  = '0;
          ptr_d     = ptr_nxt;
          state_d   = StFull;
        end else if (timeout_hit) begin
          req_in_d = '0;
          tmo_d    = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
          state_d  = StDrain;
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
      end
      // One grace cycle so an ack that races the timeout is still captured.
      StDrain: begin
        ptr_d = ptr_nxt;
        if (ack_sel) begin
          dout_d    = din_sel;
          sel_out_d = sel_q;
          state_d   = StFull;
        end else begin
          state_d = StIdle;
        end
      end
      StFull: begin
        if (req_out) begin
          ack_out_d = 1'b1;
          grant_d   = grant_q + 32'd1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      sel_q     <= '0;
      sel_out_q <= '0;
      wcnt_q    <= '0;
      req_in_q  <= '0;
      ack_out_q <= 1'b0;
      dout_q    <= '0;
      grant_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      sel_out_q <= sel_out_d;
      wcnt_q    <= wcnt_d;
      req_in_q  <= req_in_d;
      ack_out_q <= ack_out_d;
      dout_q    <= dout_d;
      grant_q   <= grant_d;
      tmo_q     <= tmo_d;
    end
  end

  assign req_in        = req_in_q;
  assign ack_out       = ack_out_q;
  assign dout          = dout_q;
  assign sel_out       = sel_out_q;
  assign grant_count   = grant_q;
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Self-checking bench for rr_channel_arbiter: behavioural producers push expected words to a
// scoreboard queue as they ack; a downstream monitor pops and compares on every ack_out.
module tb_rr_channel_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned WL = 8;

  typedef struct packed {
    logic [1:0]    sel;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    en_mask, req_in, ack_in;
  logic [DW*N-1:0] din;
  logic            req_out, ack_out;
  logic [DW-1:0]   dout;
  logic [1:0]      sel_out;
  logic [31:0]     grant_count;
  logic [15:0]     timeout_count;

  exp_t exp_q[$];
  int   got_sel[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_ack = -1;
  logic prev_ack = 1'b0;
  bit   check_spacing = 1'b0;
  int   lat[N];
  bit   ovr[N];
  exp_t mon_e;

  rr_channel_arbiter #(
    .data_width(DW),
    .num_inputs(N),
    .wait_limit(WL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_mask      (en_mask),
    .req_in       (req_in),
    .ack_in       (ack_in),
    .din          (din),
    .req_out      (req_out),
    .ack_out      (ack_out),
    .dout         (dout),
    .sel_out      (sel_out),
    .grant_count  (grant_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // Producers: source i acks after seeing req for lat[i] cycles (0 = never), word i*1000+k.
  initial begin
    int   cnt[N];
    int   seen[N];
    bit   fire[N];
    logic [DW-1:0] w;
    exp_t pe;
    for (int i = 0; i < N; i++) begin
      cnt[i]  = 0;
      seen[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        fire[i] = (lat[i] != 0) && req_in[i] && !ack_in[i] && (seen[i] + 1 == lat[i]);
        if (req_in[i] && !ack_in[i] && !fire[i]) seen[i]++;
        else seen[i] = 0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        ack_in[i] = fire[i];
        if (fire[i]) begin
          w = ovr[i] ? 32'hABCD : 32'(i * 1000 + cnt[i]);
          din[i*DW +: DW] = w;
          pe.sel  = 2'(i);
          pe.data = w;
          exp_q.push_back(pe);
          cnt[i]++;
        end
      end
    end
  end

  // Downstream monitor and scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      last_ack = -1;
      prev_ack = 1'b0;
    end else begin
      cyc++;
      vectors++;
      if ($countones(req_in) > 1) begin
        miscompares++;
        $display("FAIL req_onehot req_in=%b required at most one bit set", req_in);
      end
      if (ack_out) begin
        got_sel.push_back(int'(sel_out));
        vectors++;
        if (prev_ack) begin
          miscompares++;
          $display("FAIL ack_out_consecutive got high twice, required single-cycle pulse");
        end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_extra got sel=%0d dout=%h, required no delivery",
                   sel_out, dout);
        end else begin
          mon_e = exp_q.pop_front();
          if (dout !== mon_e.data || sel_out !== mon_e.sel) begin
            miscompares++;
            $display("FAIL scoreboard got sel=%0d dout=%h, required sel=%0d dout=%h",
                     sel_out, dout, mon_e.sel, mon_e.data);
          end
        end
        if (check_spacing && last_ack >= 0) begin
          vectors++;
          if (cyc - last_ack != 4) begin
            miscompares++;
            $display("FAIL ack_spacing got %0d cycles, required 4", cyc - last_ack);
          end
        end
        last_ack = cyc;
      end
      prev_ack = ack_out;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    exp_q.delete();
    got_sel.delete();
    rst = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    int c = 0;
    while (got_sel.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    ok = (got_sel.size() >= n);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({req_in, ack_out, dout, sel_out, grant_count, timeout_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_values got req=%b ack=%b dout=%h sel=%0d gc=%0d tc=%0d, required 0",
               req_in, ack_out, dout, sel_out, grant_count, timeout_count);
    end
  endtask

  task automatic test_single_source();
    bit ok;
    int bad = 0;
    do_reset();
    check_spacing = 1'b1;
    en_mask = 4'b0001;
    req_out = 1'b1;
    wait_words(5000, 5000 * 4 + 100, ok);
    en_mask = 4'b0000;
    check_spacing = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_count got %0d words, required 5000", got_sel.size());
    end
    vectors++;
    if (grant_count !== 32'd5000) begin
      miscompares++;
      $display("FAIL single_grant_count got %0d, required 5000", grant_count);
    end
    settle();
    foreach (got_sel[k]) if (got_sel[k] != 0) bad++;
    vectors++;
    if (bad != 0 || got_sel.size() != 5000 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_tail got bad_sel=%0d words=%0d pending=%0d, required 0/5000/0",
               bad, got_sel.size(), exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int bad = 0;
    do_reset();
    en_mask = 4'b1111;
    req_out = 1'b1;
    wait_words(40, 40 * 4 + 50, ok);
    en_mask = 4'b0000;
    vectors++;
    if (!ok || grant_count !== 32'd40) begin
      miscompares++;
      $display("FAIL rr_count got words=%0d gc=%0d, required 40/40", got_sel.size(), grant_count);
    end
    foreach (got_sel[k]) if (got_sel[k] != k % 4) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rr_order got %0d out-of-order grants, required 0", bad);
    end
    settle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rr_pending got %0d undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_mask_change();
    bit ok1, ok2;
    int bad = 0;
    int want;
    do_reset();
    en_mask = 4'b1010;
    req_out = 1'b1;
    wait_words(8, 8 * 4 + 50, ok1);
    en_mask = 4'b0100;
    wait_words(12, 4 * 4 + 50, ok2);
    en_mask = 4'b0000;
    vectors++;
    if (!ok1 || !ok2) begin
      miscompares++;
      $display("FAIL mask_count got %0d words, required 12", got_sel.size());
    end
    foreach (got_sel[k]) begin
      want = (k < 8) ? ((k % 2 == 1) ? 3 : 1) : 2;
      if (got_sel[k] != want) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mask_order got %0d wrong grants, required 0", bad);
    end
    settle();
    vectors++;
    if (got_sel.size() != 12 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mask_tail got words=%0d pending=%0d, required 12/0",
               got_sel.size(), exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int c = 0, run = 0, gap = 0, ones = 0;
    do_reset();
    lat[1] = 0;
    en_mask = 4'b0011;
    req_out = 1'b1;
    while (!req_in[1] && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    while (req_in[1] && run < 40) begin
      run++;
      @(negedge clk);
      #1;
    end
    while (req_in == 4'b0000 && gap < 40) begin
      gap++;
      @(negedge clk);
      #1;
    end
    vectors++;
    if (run != int'(WL)) begin
      miscompares++;
      $display("FAIL timeout_req_len got %0d cycles, required %0d", run, WL);
    end
    vectors++;
    if (gap != 2 || req_in !== 4'b0001) begin
      miscompares++;
      $display("FAIL timeout_next got gap=%0d req=%b, required gap=2 req=0001", gap, req_in);
    end
    vectors++;
    if (timeout_count !== 16'd1) begin
      miscompares++;
      $display("FAIL timeout_count got %0d, required 1", timeout_count);
    end
    wait_words(2, 60, ok);
    en_mask = 4'b0000;
    settle();
    foreach (got_sel[k]) if (got_sel[k] == 1) ones++;
    vectors++;
    if (!ok || got_sel.size() != 2 || ones != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_words got words=%0d from_src1=%0d pending=%0d, required 2/0/0",
               got_sel.size(), ones, exp_q.size());
    end
    lat[1] = 1;
  endtask

  task automatic test_late_ack();
    bit ok;
    do_reset();
    lat[1] = int'(WL);
    ovr[1] = 1'b1;
    en_mask = 4'b0010;
    req_out = 1'b1;
    wait_words(1, 60, ok);
    en_mask = 4'b0000;
    vectors++;
    if (!ok || dout !== 32'hABCD || sel_out !== 2'd1) begin
      miscompares++;
      $display("FAIL late_ack_word got ok=%0d dout=%h sel=%0d, required dout=0000abcd sel=1",
               ok, dout, sel_out);
    end
    vectors++;
    if (timeout_count !== 16'd1 || grant_count !== 32'd1) begin
      miscompares++;
      $display("FAIL late_ack_counts got tc=%0d gc=%0d, required 1/1", timeout_count, grant_count);
    end
    settle();
    vectors++;
    if (got_sel.size() != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL late_ack_once got words=%0d pending=%0d, required 1/0",
               got_sel.size(), exp_q.size());
    end
    lat[1] = 1;
    ovr[1] = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    bit ok;
    int bad = 0;
    exp_t held;
    do_reset();
    en_mask = 4'b0111;
    req_out = 1'b1;
    wait_words(1, 40, ok);
    req_out = 1'b0;
    settle();
    vectors++;
    if (!ok || got_sel[0] != 0 || exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL bp_setup got ok=%0d held_words=%0d, required 1/1", ok, exp_q.size());
    end
    held = (exp_q.size() > 0) ? exp_q[0] : '0;
    repeat (50) begin
      @(negedge clk);
      #1;
      if (ack_out || req_in != 4'b0000 || dout !== held.data || sel_out !== held.sel) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_hold got %0d disturbed cycles, required 0 (dout=%h sel=%0d)",
               bad, held.data, held.sel);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({req_in, ack_out, dout, sel_out, grant_count, timeout_count} !== '0) begin
      miscompares++;
      $display("FAIL bp_async_reset got req=%b ack=%b dout=%h sel=%0d gc=%0d tc=%0d, required 0",
               req_in, ack_out, dout, sel_out, grant_count, timeout_count);
    end
    repeat (2) @(negedge clk);
    #1;
    exp_q.delete();
    got_sel.delete();
    rst = 1'b0;
    req_out = 1'b1;
    wait_words(1, 40, ok);
    en_mask = 4'b0000;
    vectors++;
    if (!ok || got_sel[0] != 0) begin
      miscompares++;
      $display("FAIL bp_first_after_reset got ok=%0d sel=%0d, required sel=0",
               ok, ok ? got_sel[0] : -1);
    end
    settle();
    vectors++;
    if (exp_q.size() != 0 || got_sel.size() != 1) begin
      miscompares++;
      $display("FAIL bp_tail got pending=%0d words=%0d, required 0/1",
               exp_q.size(), got_sel.size());
    end
  endtask

  initial begin
    rst     = 1'b1;
    en_mask = '0;
    req_out = 1'b0;
    ack_in  = '0;
    din     = '0;
    for (int i = 0; i < N; i++) begin
      lat[i] = 1;
      ovr[i] = 1'b0;
    end
    #1;
    test_reset();
    test_single_source();
    test_round_robin();
    test_mask_change();
    test_timeout();
    test_late_ack();
    test_backpressure_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_channel_arbiter.md
# rr_channel_arbiter

Round-robin N-to-1 channel arbiter that lets N producer channels share one downstream datapath input, such as a single `async_operator` input port or a `consumer`. It pulls one word at a time from the selected source using the codebase req/ack pull handshake and holds it in a single-entry buffer. It then hands the word downstream with the same handshake, tagged with its source index. A per-grant timeout keeps one stalled source from blocking the others.

## Interface
- `data_width`, 32, word width.
- `num_inputs`, 4, number of source channels N (N ≥ 1).
- `wait_limit`, 16, cycles to wait for a source ack before withdrawing the request; 0 means no timeout.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en_mask`  in  N  per-source enable; 0 means the source is skipped by arbitration.
- `req_in`  out  N  level request to source i (at most one bit high).
- `ack_in`  in  N  one-cycle ack pulse from source i; the word is valid in the same cycle.
- `din`  in  data_width*N  source words; source i occupies bits [data_width*(i+1)-1 : data_width*i].
- `req_out`  in  1  level request from downstream.
- `ack_out`  out  1  one-cycle ack pulse to downstream.
- `dout`  out  data_width  buffered word; stable from capture until the next capture.
- `sel_out`  out  SW  source index of `dout`, where SW = max(1, clog2(N)).
- `grant_count`  out  32  words delivered downstream; wraps modulo 2^32.
- `timeout_count`  out  16  number of timeouts; saturates at 0xFFFF.

## Operation
- States are IDLE, WAIT, DRAIN and FULL. Internal registers are `ptr` (SW bits), `sel` and the wait counter `wcnt`.
- **IDLE**
  - If `en_mask` is non-zero, set `sel` to the first enabled index at or after `ptr`, searching cyclically. Set `req_in[sel]`=1, clear `wcnt`, and go to WAIT.
  - If `en_mask` is 0, remain in IDLE.
- **WAIT**
  - If `ack_in[sel]`=1: capture the `din` slice for `sel` into `dout`, set `sel_out`=`sel`, clear `req_in`, set `ptr`=(`sel`+1) mod N, and go to FULL.
  - Otherwise, if `wait_limit`≠0 and `wcnt`=`wait_limit`-1: clear `req_in`, increment `timeout_count` (saturating), and go to DRAIN.
  - Otherwise, increment `wcnt`.
- **DRAIN** (one cycle, absorbs a late ack)
  - If `ack_in[sel]`=1: capture as in WAIT and go to FULL.
  - Otherwise: set `ptr`=(`sel`+1) mod N and go to IDLE.
- **FULL**
  - If `req_out`=1: `ack_out`=1 for exactly one cycle, increment `grant_count`, and go to IDLE.
  - Otherwise, hold the word indefinitely.
- Acks on non-selected inputs, or acks in IDLE/FULL, are ignored. They never corrupt `dout`.
- Clearing `en_mask[sel]` during WAIT does not abort the grant. The grant completes by ack or by timeout.
- `en_mask` changes take effect at the next IDLE decision.
- N=1: `ptr` stays at 0. Source 0 is granted repeatedly while enabled.

## Timing
- Values after reset: `req_in`=0, `ack_out`=0, `dout`=0, `sel_out`=0, `grant_count`=0, `timeout_count`=0, `ptr`=0, state IDLE. Reset takes effect immediately and is independent of `clk`.
- Reset asserted mid-transfer drops all requests and any buffered word. No `ack_out` is issued for that word.
- Nominal pipeline with a producer that acks one cycle after seeing req, and `req_out` held high:
  - edge 0: IDLE→WAIT, `req_in` rises.
  - edge 1: the source raises ack.
  - edge 2: capture, FULL.
  - edge 3: `ack_out` rises.
  - edge 4: `ack_out` falls, IDLE→WAIT.
  - Throughput is one word per 4 cycles.
- `req_in[sel]` is cleared on the edge that samples the ack. A producer guarded by `req & ~ack` therefore never double-acks.
- `ack_out` is never high on two consecutive cycles.
- `dout` and `sel_out` change only on a capture edge. They are valid and stable while `ack_out`=1.
- Timeout: `req_in` is high for exactly `wait_limit` cycles, followed by one DRAIN cycle. A silent source therefore costs `wait_limit`+2 cycles before the next grant.

## Test plan
- Single source: N=4, `en_mask`=0001, source 0 sends 0,1,2,…, `req_out`=1, no fails. Required: 5000 words 0..4999 in order, `sel_out`=0, `grant_count`=5000, each `ack_out` pulse 4 cycles apart.
- Round-robin fairness: `en_mask`=1111, source i sends i*1000+k. Required: `sel_out` sequence 0,1,2,3,0,…, with each source's words in order.
- Skip and mask change: `en_mask`=1010 gives grants 1,3,1,3. Switching mid-run to 0100 gives 2 only, starting at the next IDLE decision.
- Timeout: `wait_limit`=8, source 1 never acks, `en_mask`=0011. Required: `req_in[1]` high for exactly 8 cycles, then DRAIN, `timeout_count` increments, source 0 is granted next, and no word is delivered from source 1.
- Late ack in DRAIN: source acks on the first DRAIN cycle with 0xABCD. Required: `dout`=0xABCD with the correct `sel_out`, delivered once; `timeout_count` still increments.
- Backpressure and reset: hold `req_out`=0 with a word in FULL for 50 cycles. Required: `dout` stable, no `ack_out`, no new `req_in`. Then assert `rst`. Required: all outputs return to their reset values immediately; after release, the first grant goes to the lowest enabled index.
